// File: rtl/layer_output_serializer.sv
// ---------------------------------------------------------------------------
// layer_output_serializer
//
// Sits between two neuron layers. It collects the parallel outputs of
// numNeurons neurons. Each lane reports its result with a one-cycle outvalid
// pulse, and lanes may report on different cycles. Once every lane has
// reported, the block replays the values in lane order as a paced serial
// stream. That stream feeds the shared myinput/myinputValid of the next layer.
// Neurons have no ready signal, so successive data_valid pulses are spaced
// exactly gapCycles apart.
//
// Ports
//   clk          in   1                      clock, all state on posedge
//   rst          in   1                      asynchronous, active-high reset
//   x_in         in   numNeurons*dataWidth   lane k = x_in[k*dataWidth +: dataWidth]
//   x_valid      in   numNeurons             lane k outvalid (1-cycle pulse)
//   data_out     out  dataWidth              serialized value, registered
//   data_valid   out  1                      1-cycle pulse per value
//   busy         out  1                      high while streaming
//   overflow     out  1                      sticky: a lane pulse was dropped
//   argmax_out   out  $clog2(numNeurons)     (SER_ARGMAX_EN) index of largest value so far
//   argmax_valid out  1                      (SER_ARGMAX_EN) pulse after final emission
//
// Build option
//   SER_ARGMAX_EN : when defined, adds a running unsigned argmax over the
//                   emitted values. Use it as the classifier output of the
//                   final layer.
// ---------------------------------------------------------------------------

// Per-lane capture slot: holds one neuron result and its "reported" flag.
module layer_output_serializer_lane #(
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap,     // lane pulse accepted this edge
  input  logic                 clr,     // capture round complete
  input  logic [dataWidth-1:0] din,
  output logic [dataWidth-1:0] data_o,
  output logic                 mask_o
);
  logic [dataWidth-1:0] data_q, data_d;
  logic                 mask_q, mask_d;

  always_comb begin
    data_d = data_q;
    if (cap) data_d = din;
    // Clear wins over a same-edge pulse. That pulse's data is still stored
    // and gets streamed in the round now starting.
    mask_d = clr ? 1'b0 : (mask_q | cap);
  end

  // Payload needs no reset. A slot is only streamed after it is rewritten.
  always_ff @(posedge clk) data_q <= data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= 1'b0;
    else     mask_q <= mask_d;
  end

  assign data_o = data_q;
  assign mask_o = mask_q;
endmodule

module layer_output_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int gapCycles  = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] x_in,
  input  logic [numNeurons-1:0]           x_valid,
  output logic [dataWidth-1:0]            data_out,
  output logic                            data_valid,
  output logic                            busy,
  output logic                            overflow
`ifdef SER_ARGMAX_EN
  ,
  output logic [$clog2(numNeurons)-1:0]   argmax_out,
  output logic                            argmax_valid
`endif
);
  localparam int IW = $clog2(numNeurons);
  localparam int GW = $clog2(gapCycles) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(numNeurons - 1);
  localparam logic [GW-1:0] GAP_M1   = GW'(gapCycles - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                              state_q, state_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic [GW-1:0]                       gcnt_q, gcnt_d;
  logic [dataWidth-1:0]                data_out_q, data_out_d;
  logic                                data_valid_q, data_valid_d;
  logic                                overflow_q, overflow_d;

  logic                                idle;
  logic                                full;
  logic                                emit;
  logic [numNeurons-1:0]               cap;
  logic [numNeurons-1:0]               mask;
  logic [numNeurons-1:0][dataWidth-1:0] lane_data;

  assign idle = (state_q == IDLE);
  // Lanes are only written while collecting. During SEND the buffer is being
  // read out, so any pulse is dropped.
  assign cap  = x_valid & {numNeurons{idle}};
  // Completion counts the pulses landing on this same edge.
  assign full = idle && (&(mask | x_valid));
  assign emit = (state_q == SEND) && (gcnt_q == '0);

  for (genvar g = 0; g < numNeurons; g++) begin : g_lane
    layer_output_serializer_lane #(.dataWidth(dataWidth)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .cap    (cap[g]),
      .clr    (full),
      .din    (x_in[g*dataWidth +: dataWidth]),
      .data_o (lane_data[g]),
      .mask_o (mask[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gcnt_d       = gcnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q | (!idle && (|x_valid));
    case (state_q)
      IDLE: begin
        if (full) begin
          state_d = SEND;
          idx_d   = '0;
          gcnt_d  = '0;
        end
      end
      SEND: begin
        if (emit) begin
          data_out_d   = lane_data[idx_q];
          data_valid_d = 1'b1;
          gcnt_d       = GAP_M1;
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      gcnt_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gcnt_q       <= gcnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q == SEND);
  assign overflow   = overflow_q;

`ifdef SER_ARGMAX_EN
  logic [IW-1:0]        argmax_q, argmax_d;
  logic [dataWidth-1:0] max_q, max_d;
  logic                 argmax_valid_q, argmax_valid_d;

  always_comb begin
    argmax_d = argmax_q;
    max_d    = max_q;
    // data_valid is only high in IDLE right after the final emission. This
    // makes the edge where it drops the classifier-result edge.
    argmax_valid_d = data_valid_q && idle;
    // Strict compare keeps the lower index on ties. Lane 0 reseeds each round.
    if (emit && ((idx_q == '0) || (lane_data[idx_q] > max_q))) begin
      argmax_d = idx_q;
      max_d    = lane_data[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      argmax_q       <= '0;
      max_q          <= '0;
      argmax_valid_q <= 1'b0;
    end else begin
      argmax_q       <= argmax_d;
      max_q          <= max_d;
      argmax_valid_q <= argmax_valid_d;
    end
  end

  assign argmax_out   = argmax_q;
  assign argmax_valid = argmax_valid_q;
`endif
endmodule

// File: tb/tb_layer_output_serializer.sv
// ---------------------------------------------------------------------------
// tb_layer_output_serializer
// Two serializers (N=4, gap=6 and gap=1) share one input bus. An
// event-timed reference model checks every output after every edge. A
// constant vector table covers the basic stream, and hand sequences cover
// the multi-cycle corners. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_layer_output_serializer;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] x_in;
  logic [N-1:0]   x_valid;
  logic [W-1:0]   a_do, b_do;
  logic           a_dv, b_dv, a_busy, b_busy, a_ovf, b_ovf;
`ifdef SER_ARGMAX_EN
  logic [1:0]     a_am, b_am;
  logic           a_amv, b_amv;
`endif

  always #5 clk = ~clk;

  layer_output_serializer #(.numNeurons(N), .dataWidth(W), .gapCycles(6)) u_a (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
    .data_out(a_do), .data_valid(a_dv), .busy(a_busy), .overflow(a_ovf)
`ifdef SER_ARGMAX_EN
    , .argmax_out(a_am), .argmax_valid(a_amv)
`endif
  );

  layer_output_serializer #(.numNeurons(N), .dataWidth(W), .gapCycles(1)) u_b (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
    .data_out(b_do), .data_valid(b_dv), .busy(b_busy), .overflow(b_ovf)
`ifdef SER_ARGMAX_EN
    , .argmax_out(b_am), .argmax_valid(b_amv)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  // A capture round completes on edge E0, and the lane values are snapshotted
  // there. Edge E0+t then emits snapshot[(t-1)/gap] when (t-1) is a multiple
  // of gap. The round ends at t = 1+(N-1)*gap.
  int         gap_m[2] = '{6, 1};
  logic [W-1:0] m_buf[2][N];
  logic [W-1:0] m_snap[2][N];
  bit         m_mask[2][N];
  bit         m_send[2];
  int         m_t[2];
  logic [W-1:0] m_do[2];
  bit         m_dv[2];
  bit         m_ovf[2];

  function automatic void model_reset(input int i);
    m_send[i] = 0; m_t[i] = 0; m_do[i] = '0; m_dv[i] = 0; m_ovf[i] = 0;
    for (int k = 0; k < N; k++) m_mask[i][k] = 0;
  endfunction

  function automatic void model_edge(input int i, input logic [N*W-1:0] xin, input logic [N-1:0] xv);
    bit all;
    if (m_send[i]) begin
      m_t[i]++;
      if (|xv) m_ovf[i] = 1;
      if ((m_t[i] - 1) % gap_m[i] == 0) begin
        m_dv[i] = 1;
        m_do[i] = m_snap[i][(m_t[i] - 1) / gap_m[i]];
      end else m_dv[i] = 0;
      if (m_t[i] == 1 + (N - 1) * gap_m[i]) m_send[i] = 0;
    end else begin
      m_dv[i] = 0;
      all = 1;
      for (int k = 0; k < N; k++) begin
        if (xv[k]) begin
          m_buf[i][k]  = xin[k*W +: W];
          m_mask[i][k] = 1;
        end
        all = all & m_mask[i][k];
      end
      if (all) begin
        for (int k = 0; k < N; k++) begin
          m_snap[i][k] = m_buf[i][k];
          m_mask[i][k] = 0;
        end
        m_send[i] = 1;
        m_t[i]    = 0;
      end
    end
  endfunction

  task automatic check_model();
    chk("A.data_valid", a_dv,   m_dv[0]);
    chk("A.data_out",   a_do,   m_do[0]);
    chk("A.busy",       a_busy, m_send[0]);
    chk("A.overflow",   a_ovf,  m_ovf[0]);
    chk("B.data_valid", b_dv,   m_dv[1]);
    chk("B.data_out",   b_do,   m_do[1]);
    chk("B.busy",       b_busy, m_send[1]);
    chk("B.overflow",   b_ovf,  m_ovf[1]);
  endtask

  // One clock edge: advance model, then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset(0); model_reset(1);
    end else begin
      model_edge(0, x_in, x_valid);
      model_edge(1, x_in, x_valid);
    end
    #1;
    check_model();
  endtask

  task automatic pulse(input logic [N-1:0] v, input logic [N*W-1:0] d);
    x_valid = v; x_in = d;
    tick();
    x_valid = '0;
  endtask

  task automatic wait_idle(input int budget);
    x_valid = '0;
    for (int i = 0; i < budget; i++) begin
      if (!a_busy && !b_busy) break;
      tick();
    end
    n_tests++;
    if (a_busy || b_busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy a=%0b b=%0b required 0 0", a_busy, b_busy);
    end
    tick();
  endtask

  typedef struct {
    logic [N-1:0]   xv;
    logic [N*W-1:0] xin;
    logic           edv;
    logic [W-1:0]   edo;
    logic           ebusy;
  } vec_t;
  vec_t tv[21];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] d;
    // Vector table for the gap=6 instance: all lanes pulse together.
    tv[0] = '{xv: 4'hf, xin: {16'd4, 16'd3, 16'd2, 16'd1}, edv: 1'b0, edo: 16'd0, ebusy: 1'b1};
    for (int r = 1; r < 21; r++) begin
      tv[r].xv    = '0;
      tv[r].xin   = '0;
      tv[r].edv   = (r <= 19) && ((r - 1) % 6 == 0);
      tv[r].edo   = W'((r - 1) / 6 + 1);
      tv[r].ebusy = (r < 19);
    end

    rst = 1'b1; x_valid = '0; x_in = '0;
    model_reset(0); model_reset(1);
    tick(); tick();
    rst = 1'b0;
    chk("reset.a_do",   a_do,   16'd0);
    chk("reset.a_dv",   a_dv,   1'b0);
    chk("reset.a_busy", a_busy, 1'b0);
    chk("reset.a_ovf",  a_ovf,  1'b0);
`ifdef SER_ARGMAX_EN
    chk("reset.a_am",  a_am,  2'd0);
    chk("reset.a_amv", a_amv, 1'b0);
`endif

    // Test 1: table-driven stream.
    for (int r = 0; r < 21; r++) begin
      x_valid = tv[r].xv; x_in = tv[r].xin;
      tick();
      chk($sformatf("t1.dv[%0d]", r),   a_dv,   tv[r].edv);
      chk($sformatf("t1.do[%0d]", r),   a_do,   tv[r].edo);
      chk($sformatf("t1.busy[%0d]", r), a_busy, tv[r].ebusy);
      chk($sformatf("t1.ovf[%0d]", r),  a_ovf,  1'b0);
    end
    wait_idle(10);

    // Test 2: staggered arrival; order out is by lane.
    d = {16'h0a3, 16'h0a2, 16'h0a1, 16'h0a0};
    pulse(4'b0010, d); chk("t2.busy1", a_busy, 1'b0);
    pulse(4'b0001, d); chk("t2.busy2", a_busy, 1'b0);
    pulse(4'b0100, d); chk("t2.busy3", a_busy, 1'b0);
    pulse(4'b1000, d); chk("t2.busyE0", a_busy, 1'b1); chk("t2.dvE0", a_dv, 1'b0);
    tick(); chk("t2.dv1", a_dv, 1'b1); chk("t2.do1", a_do, 16'h0a0);
    repeat (3) tick();
    // Test 3: lane pulse during SEND is dropped and sets sticky overflow.
    pulse(4'b0100, {4{16'hffff}});
    chk("t3.ovf", a_ovf, 1'b1);
    repeat (7) tick();
    tick(); chk("t3.dv3", a_dv, 1'b1); chk("t3.do3", a_do, 16'h0a2);
    wait_idle(40);
    chk("t3.ovf_sticky", a_ovf, 1'b1);
    pulse(4'hf, {16'd24, 16'd23, 16'd22, 16'd21});
    tick(); chk("t3.recap_dv", a_dv, 1'b1); chk("t3.recap_do", a_do, 16'd21);
    chk("t3.ovf_still", a_ovf, 1'b1);
    wait_idle(40);

    // Test 4: gap=1 back-to-back, pulse on the first IDLE edge is accepted.
    d = {16'h44, 16'h43, 16'h42, 16'h41};
    pulse(4'hf, d);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("t4.b_dv[%0d]", j), b_dv, 1'b1);
      chk($sformatf("t4.b_do[%0d]", j), b_do, d[j*W +: W]);
    end
    chk("t4.b_idle", b_busy, 1'b0);
    d = {16'h58, 16'h57, 16'h56, 16'h55};
    pulse(4'b0001, d);
    chk("t4.b_ovf", b_ovf, 1'b0); chk("t4.b_busy0", b_busy, 1'b0);
    pulse(4'b1110, d);
    chk("t4.b_start", b_busy, 1'b1);
    tick(); chk("t4.b_lane0", b_do, 16'h55);
    wait_idle(40);

    // Test 5: reset mid-stream.
    pulse(4'hf, {16'd64, 16'd63, 16'd62, 16'd61});
    repeat (7) tick();
    chk("t5.second", a_do, 16'd62);
    #2; rst = 1'b1; #1;
    chk("t5.a_do", a_do, 16'd0); chk("t5.a_dv", a_dv, 1'b0);
    chk("t5.a_busy", a_busy, 1'b0); chk("t5.a_ovf", a_ovf, 1'b0);
    model_reset(0); model_reset(1);
    tick();
    rst = 1'b0;
    pulse(4'hf, {16'd74, 16'd73, 16'd72, 16'd71});
    tick(); chk("t5.restart_dv", a_dv, 1'b1); chk("t5.restart_do", a_do, 16'd71);
    wait_idle(40);

    // Randomized traffic against the model.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(99) == 0) begin
        x_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) x_valid[k] = ($urandom_range(99) < 25);
        x_in = {$urandom, $urandom};
        tick();
      end
    end
    wait_idle(40);

`ifdef SER_ARGMAX_EN
    // Test 6: argmax over 5,9,9,2 -> index 1 (tie keeps lower).
    rst = 1'b1; #1;
    model_reset(0); model_reset(1);
    tick();
    rst = 1'b0;
    pulse(4'hf, {16'd2, 16'd9, 16'd9, 16'd5});
    for (int j = 0; j < 19; j++) begin
      tick();
      chk($sformatf("t6.amv_low[%0d]", j), a_amv, 1'b0);
    end
    chk("t6.last_dv", a_dv, 1'b1);
    tick(); chk("t6.amv", a_amv, 1'b1); chk("t6.am", a_am, 2'd1);
    tick(); chk("t6.amv_once", a_amv, 1'b0); chk("t6.am_hold", a_am, 2'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
